bcd_digit_validator: RTL and testbench
======================================

Name: bcd_digit_validator

Overview:
- Checks packed BCD digits and flags each nibble whose value is above 9.
- Provides a combinational flag path, used directly by arithmetic blocks such as the BCD multiplier's input check.
- Also provides a registered path with a valid strobe, per-digit error flags, a sticky error bit and a saturating error counter.
- Sits in front of BCD arithmetic; an error flag of 1 means the digit is invalid.

Parameters:
- DIGITS, 1, number of 4-bit BCD digits checked in parallel (legal range 1..16).
- CNT_W, 8, width of the saturating invalid-word counter.

Ports:
- clk  input  1  single system clock; all registers update on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies bcd_in for the registered path.
- bcd_in  input  [0:4*DIGITS-1]  packed digits; digit k occupies bits [4k:4k+3], bit 4k is that digit's MSB; digit 0 is the most significant.
- comb_err  output  [0:DIGITS-1]  combinational per-digit flag; bit k = 1 iff digit k > 9; ignores in_valid and rst.
- out_valid  output  1  registered copy of in_valid.
- digit_err  output  [0:DIGITS-1]  registered per-digit flags.
- any_err  output  1  registered OR of digit_err.
- sticky_err  output  1  set by any invalid accepted word; cleared only by rst.
- err_count  output  CNT_W  number of accepted words with any_err = 1; saturates.

Behaviour:
- Digit validity rule:
  - Nibble values 0x0..0x9 are valid (flag 0).
  - Values 0xA..0xF are invalid (flag 1).
  - Flag = b3 & (b2 | b1), where b3 is the nibble MSB.
- comb_err:
  - Purely combinational, zero latency.
  - Independent of clk, rst and in_valid.
  - Exists so the BCD multiplier can test its inputs without a clock.
- Registered path, on each rising clk edge:
  - If rst = 1: out_valid, digit_err, any_err and sticky_err go to 0; err_count goes to 0.
  - Else if in_valid = 1: out_valid <= 1; digit_err <= comb_err; any_err <= |comb_err.
  - Also when in_valid = 1 and any digit is invalid: sticky_err <= 1, and err_count increments by 1 unless it is already all-ones.
  - Else (in_valid = 0): out_valid <= 0. digit_err and any_err hold their last values. sticky_err and err_count hold.
- Latency: 1 clock from in_valid/bcd_in to out_valid/digit_err.
- Throughput: one word per cycle; there is no backpressure.
- Reset values after any rst cycle: all registered outputs are 0.
- Reset mid-stream: rst has priority over a simultaneous in_valid; that word is dropped and not counted.
- Saturation: err_count stays at 2^CNT_W-1 on further invalid words; it never wraps to 0.
- A word counts once in err_count regardless of how many of its digits are invalid.
- Inputs sampled while in_valid = 0 have no effect on registered outputs.
- No internal state besides the listed registers; no X propagation from rst.

Test Plan:
- Exhaustive single digit, DIGITS=1: drive bcd_in = 0x0..0xF with in_valid=1, one per cycle.
  - Required: comb_err = 0 for 0..9 and 1 for A..F, immediately.
  - Required: digit_err and any_err follow one cycle later.
  - Required: err_count = 6 and sticky_err = 1 at the end.
- Multiplier pairing, DIGITS=2:
  - bcd_in = 0x37 -> digit_err = 2'b00.
  - 0xA7 -> 2'b10.
  - 0x3C -> 2'b01.
  - 0xFF -> 2'b11, any_err = 1, err_count += 1 (not 2).
- Valid gating: 0xB with in_valid=0 -> comb_err = 1, but out_valid = 0 and digit_err, sticky_err and err_count unchanged next cycle.
- Reset priority: rst=1 together with in_valid=1 and bcd_in=0xE -> next cycle all registered outputs 0 and err_count = 0.
  - Then a 0x5 word -> any_err = 0, sticky_err stays 0.
- Saturation, CNT_W=3: 10 consecutive invalid words (0xA) -> err_count reads 7 after the 7th and stays 7. Then rst -> 0.
- Latency/throughput: alternate 0x9 and 0xA on consecutive cycles -> any_err toggles 0,1,0,1 delayed exactly one cycle, with out_valid held at 1.

Source files
------------

// File: rtl/bcd_digit_validator.sv
// BCD digit validator: flags packed nibbles above 9 combinationally, and also
// registers the flags with a valid strobe, a sticky error bit and a saturating error counter.
module bcd_digit_validator #(
  parameter int DIGITS = 1,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [0:4*DIGITS-1] bcd_in,
  output logic [0:DIGITS-1]   comb_err,
  output logic                out_valid,
  output logic [0:DIGITS-1]   digit_err,
  output logic                any_err,
  output logic                sticky_err,
  output logic [CNT_W-1:0]    err_count
);

  logic word_err;

  // Digit k is bcd_in[4k:4k+3] with bit 4k as its MSB; values 0xA..0xF are invalid.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [3:0] nib;
    assign nib         = bcd_in[4*k +: 4];
    assign comb_err[k] = nib[3] & (nib[2] | nib[1]);
  end

  assign word_err = |comb_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      digit_err  <= '0;
      any_err    <= 1'b0;
      sticky_err <= 1'b0;
      err_count  <= '0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      digit_err <= comb_err;
      any_err   <= word_err;
      // Each bad word counts once, no matter how many of its digits are invalid.
      if (word_err) begin
        sticky_err <= 1'b1;
        if (err_count != {CNT_W{1'b1}}) begin
          err_count <= err_count + 1'b1;
        end
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_digit_validator.sv
// Self-checking bench: three validator instances (1, 2 and 4 digits) checked against
// an arithmetic reference model under directed and randomized stimulus.
module tb_bcd_digit_validator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] data;

  always #5 clk = ~clk;

  logic [0:0] comb1, dig1;
  logic       ov1, any1, st1;
  logic [7:0] cnt1;

  logic [1:0] comb2, dig2;
  logic       ov2, any2, st2;
  logic [7:0] cnt2;

  logic [3:0] comb3, dig3;
  logic       ov3, any3, st3;
  logic [2:0] cnt3;

  bcd_digit_validator #(.DIGITS(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .bcd_in(data[3:0]),
    .comb_err(comb1), .out_valid(ov1), .digit_err(dig1), .any_err(any1),
    .sticky_err(st1), .err_count(cnt1)
  );

  bcd_digit_validator #(.DIGITS(2), .CNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .bcd_in(data[7:0]),
    .comb_err(comb2), .out_valid(ov2), .digit_err(dig2), .any_err(any2),
    .sticky_err(st2), .err_count(cnt2)
  );

  bcd_digit_validator #(.DIGITS(4), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .bcd_in(data),
    .comb_err(comb3), .out_valid(ov3), .digit_err(dig3), .any_err(any3),
    .sticky_err(st3), .err_count(cnt3)
  );

  int errors = 0;
  int checks = 0;

  int          nDig[3] = '{1, 2, 4};
  int          cMax[3] = '{255, 255, 7};
  logic [15:0] mDig[3];
  bit          mOv[3], mAny[3], mSt[3];
  int          mCnt[3];

  // Digit 0 is the most significant nibble of the word; its flag lands in the top bit.
  function automatic logic [15:0] refFlags(int d, logic [15:0] w);
    logic [15:0] f;
    int nib;
    f = '0;
    for (int k = 0; k < d; k++) begin
      nib = int'((w >> (4 * (d - 1 - k))) & 16'hF);
      if (nib > 9) f[d-1-k] = 1'b1;
    end
    return f;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelUpdate(input logic r, input logic v, input logic [15:0] w);
    logic [15:0] f;
    for (int i = 0; i < 3; i++) begin
      f = refFlags(nDig[i], w);
      if (r) begin
        mOv[i] = 0; mDig[i] = '0; mAny[i] = 0; mSt[i] = 0; mCnt[i] = 0;
      end else if (v) begin
        mOv[i]  = 1;
        mDig[i] = f;
        mAny[i] = (f != 0);
        if (f != 0) begin
          mSt[i] = 1;
          if (mCnt[i] < cMax[i]) mCnt[i]++;
        end
      end else begin
        mOv[i] = 0;
      end
    end
  endtask

  task automatic checkComb();
    checkOutput("comb1", 32'(comb1), 32'(refFlags(1, data)));
    checkOutput("comb2", 32'(comb2), 32'(refFlags(2, data)));
    checkOutput("comb3", 32'(comb3), 32'(refFlags(4, data)));
  endtask

  task automatic checkRegs();
    checkOutput("ov1",  32'(ov1),  32'(mOv[0]));
    checkOutput("dig1", 32'(dig1), 32'(mDig[0]));
    checkOutput("any1", 32'(any1), 32'(mAny[0]));
    checkOutput("st1",  32'(st1),  32'(mSt[0]));
    checkOutput("cnt1", 32'(cnt1), mCnt[0]);
    checkOutput("ov2",  32'(ov2),  32'(mOv[1]));
    checkOutput("dig2", 32'(dig2), 32'(mDig[1]));
    checkOutput("any2", 32'(any2), 32'(mAny[1]));
    checkOutput("st2",  32'(st2),  32'(mSt[1]));
    checkOutput("cnt2", 32'(cnt2), mCnt[1]);
    checkOutput("ov3",  32'(ov3),  32'(mOv[2]));
    checkOutput("dig3", 32'(dig3), 32'(mDig[2]));
    checkOutput("any3", 32'(any3), 32'(mAny[2]));
    checkOutput("st3",  32'(st3),  32'(mSt[2]));
    checkOutput("cnt3", 32'(cnt3), mCnt[2]);
  endtask

  // Drive one cycle's inputs, check the combinational flags, then the registered result.
  task automatic applyStimulus(input logic r, input logic v, input logic [15:0] w);
    rst = r; in_valid = v; data = w;
    #1;
    checkComb();
    @(posedge clk);
    modelUpdate(r, v, w);
    #1;
    checkRegs();
  endtask

  logic [15:0] pairVal[4] = '{16'h0037, 16'h00A7, 16'h003C, 16'h00FF};
  logic [1:0]  pairExp[4] = '{2'b00, 2'b10, 2'b01, 2'b11};

  initial begin
    for (int i = 0; i < 3; i++) begin
      mOv[i] = 0; mDig[i] = '0; mAny[i] = 0; mSt[i] = 0; mCnt[i] = 0;
    end
    rst = 1'b1; in_valid = 1'b0; data = '0;
    @(posedge clk); #1;

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b1, 16'hFFFF);
    checkOutput("rst_cnt1", 32'(cnt1), 0);
    checkOutput("rst_ov3",  32'(ov3),  0);

    $display("[TB] exhaustive single digit");
    for (int n = 0; n < 16; n++) begin
      applyStimulus(1'b0, 1'b1, 16'(($urandom() & 32'hFFF0) | n));
      checkOutput("exh_dig", 32'(dig1), (n > 9) ? 1 : 0);
    end
    checkOutput("exh_cnt",    32'(cnt1), 6);
    checkOutput("exh_sticky", 32'(st1),  1);

    $display("[TB] multiplier pairing");
    applyStimulus(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, pairVal[i]);
      checkOutput("pair_dig", 32'(dig2), 32'(pairExp[i]));
    end
    checkOutput("pair_any", 32'(any2), 1);
    checkOutput("pair_cnt", 32'(cnt2), 3);

    $display("[TB] valid gating");
    applyStimulus(1'b0, 1'b0, 16'h000B);
    checkOutput("gate_ov",  32'(ov1),  0);
    checkOutput("gate_dig", 32'(dig1), 1);
    checkOutput("gate_cnt", 32'(cnt1), 2);
    checkOutput("gate_st",  32'(st1),  1);

    $display("[TB] reset priority");
    applyStimulus(1'b1, 1'b1, 16'h000E);
    checkOutput("rp_ov",  32'(ov1),  0);
    checkOutput("rp_any", 32'(any1), 0);
    checkOutput("rp_st",  32'(st1),  0);
    checkOutput("rp_cnt", 32'(cnt1), 0);
    applyStimulus(1'b0, 1'b1, 16'h0005);
    checkOutput("rp5_any", 32'(any1), 0);
    checkOutput("rp5_st",  32'(st1),  0);
    checkOutput("rp5_ov",  32'(ov1),  1);

    $display("[TB] saturation");
    for (int n = 1; n <= 10; n++) begin
      applyStimulus(1'b0, 1'b1, 16'h000A);
      checkOutput("sat_cnt", 32'(cnt3), (n < 7) ? n : 7);
    end
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("sat_rst", 32'(cnt3), 0);

    $display("[TB] alternating throughput");
    for (int n = 0; n < 8; n++) begin
      applyStimulus(1'b0, 1'b1, (n % 2 == 1) ? 16'h000A : 16'h0009);
      checkOutput("alt_any", 32'(any1), n % 2);
      checkOutput("alt_ov",  32'(ov1),  1);
    end

    $display("[TB] random");
    for (int n = 0; n < 300; n++) begin
      applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                    16'($urandom()));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
